// File: rtl/taxi_trip_meter.sv
// Taxi trip meter: counts wheel pulses into km/total distance with saturation,
// plus an optional waiting-time counter enabled by the TAXI_WAIT_TIMER_EN macro.
module taxi_trip_meter #(
    parameter int PPK        = 1000,
    parameter int KW         = 11,
    parameter int MW         = 21,
    parameter int WAIT_TICKS = 50
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          stop,
    input  logic          pulse,
    output logic          busy,
    output logic [KW-1:0] km,
    output logic [MW-1:0] mtr,
    output logic          co,
    output logic [15:0]   wait_sec,
    output logic          ovf
);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_RUN  = 1'b1;

    localparam int SW = $clog2(PPK);
    localparam logic [SW-1:0] SUB_MAX = SW'(PPK - 1);
    localparam logic [KW-1:0] KM_MAX  = '1;

    logic [0:0]    state_q, state_d;
    logic [SW-1:0] sub_q, sub_d;
    logic [KW-1:0] km_q, km_d;
    logic [MW-1:0] mtr_q, mtr_d;
    logic          co_q, co_d;
    logic          ovf_q, ovf_d;

    always_comb begin
        state_d = state_q;
        sub_d   = sub_q;
        km_d    = km_q;
        mtr_d   = mtr_q;
        co_d    = 1'b0;
        ovf_d   = ovf_q;
        if (state_q == S_IDLE) begin
            if (start) begin
                state_d = S_RUN;
                sub_d   = '0;
                km_d    = '0;
                mtr_d   = '0;
                ovf_d   = 1'b0;
            end
        end else begin
            if (stop)
                state_d = S_IDLE;
            // Once saturated, distance is frozen until the next trip starts.
            if (pulse && !ovf_q) begin
                if (sub_q == SUB_MAX) begin
                    if (km_q == KM_MAX) begin
                        ovf_d = 1'b1;
                    end else begin
                        sub_d = '0;
                        km_d  = km_q + 1'b1;
                        mtr_d = mtr_q + 1'b1;
                        co_d  = 1'b1;
                    end
                end else begin
                    sub_d = sub_q + 1'b1;
                    mtr_d = mtr_q + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            sub_q   <= '0;
            km_q    <= '0;
            mtr_q   <= '0;
            co_q    <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sub_q   <= sub_d;
            km_q    <= km_d;
            mtr_q   <= mtr_d;
            co_q    <= co_d;
            ovf_q   <= ovf_d;
        end
    end

    assign busy = (state_q == S_RUN);
    assign km   = km_q;
    assign mtr  = mtr_q;
    assign co   = co_q;
    assign ovf  = ovf_q;

`ifdef TAXI_WAIT_TIMER_EN
    localparam int TW = (WAIT_TICKS > 2) ? $clog2(WAIT_TICKS) : 1;
    localparam logic [TW-1:0] IDLE_MAX = TW'(WAIT_TICKS - 1);

    logic [TW-1:0] idle_q, idle_d;
    logic [15:0]   wait_q, wait_d;

    // A second elapses after WAIT_TICKS consecutive pulse-free RUN clocks.
    always_comb begin
        idle_d = idle_q;
        wait_d = wait_q;
        if (state_q == S_IDLE) begin
            if (start) begin
                idle_d = '0;
                wait_d = '0;
            end
        end else if (pulse) begin
            idle_d = '0;
        end else if (idle_q == IDLE_MAX) begin
            idle_d = '0;
            if (wait_q != 16'hFFFF)
                wait_d = wait_q + 1'b1;
        end else begin
            idle_d = idle_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idle_q <= '0;
            wait_q <= '0;
        end else begin
            idle_q <= idle_d;
            wait_q <= wait_d;
        end
    end

    assign wait_sec = wait_q;
`else
    assign wait_sec = '0;
`endif

endmodule

// File: doc/taxi_trip_meter.md
TAXI_TRIP_METER -- requirements
Module: taxi_trip_meter

Interface
REQ-001 Parameter PPK, default 1000, wheel pulses per km (>=2).
REQ-002 Parameter KW, default 11, km counter width.
REQ-003 Parameter MW, default 21, total-meter output width; must hold (2^KW-1)*PPK+PPK-1.
REQ-004 Parameter WAIT_TICKS, default 50, consecutive pulse-free clocks per waiting second (>=2).
REQ-005 clk  input  1  clock; all logic rising-edge.
REQ-006 rst  input  1  reset, asynchronous, active-high.
REQ-007 start  input  1  begin trip, single-cycle strobe, synchronous to clk.
REQ-008 stop  input  1  end trip, single-cycle strobe, synchronous to clk.
REQ-009 pulse  input  1  wheel pulse, one clk wide per pulse, synchronous to clk.
REQ-010 busy  output  1  high while trip in RUN state.
REQ-011 km  output  KW  completed km of current/last trip.
REQ-012 mtr  output  MW  total distance in pulses: km*PPK + sub-km count.
REQ-013 co  output  1  one-cycle strobe per completed km.
REQ-014 wait_sec  output  16  waiting seconds of current/last trip.
REQ-015 ovf  output  1  sticky, distance saturated.

Function
REQ-016 FSM has two states, IDLE and RUN; busy = (state==RUN), registered.
REQ-017 IDLE + start -> RUN; same cycle clears sub count, km, mtr, wait_sec, idle timer, ovf; stop in that cycle ignored.
REQ-018 RUN + stop -> IDLE; all outputs hold their values; stop wins over simultaneous start.
REQ-019 start in RUN ignored; stop in IDLE ignored.
REQ-020 pulse counted only in RUN and not in the start cycle; pulse in stop cycle counted.
REQ-021 Internal sub count runs 0..PPK-1; pulse at PPK-1 wraps it to 0 and increments km.
REQ-022 co high exactly in the cycle after the registering edge of the km increment, low otherwise.
REQ-023 mtr registered and consistent with km and sub count on every cycle (no one-cycle lag).
REQ-024 km = 2^KW-1 and sub = PPK-1 with pulse: ovf set, km/sub/mtr hold, co not asserted; further pulses ignored until next start.
REQ-025 Idle timer counts RUN clocks without pulse; reaching WAIT_TICKS-1 increments wait_sec and restarts timer at 0.
REQ-026 Any counted pulse resets idle timer to 0; wait_sec saturates at 16'hFFFF.
REQ-027 Idle timer frozen in IDLE.

Reset
REQ-028 rst high: state IDLE, busy=0, km=0, mtr=0, co=0, wait_sec=0, ovf=0, sub count and idle timer 0, immediately, independent of clk.
REQ-029 rst mid-trip aborts trip; first clock after release behaves as IDLE.

Configuration
REQ-030 Macro TAXI_WAIT_TIMER_EN defined: idle timer and wait_sec implemented per REQ-025..027.
REQ-031 Macro not defined: no idle timer logic; wait_sec constant 0; all else unchanged.

Verification (PPK=10, KW=4, MW=8, WAIT_TICKS=4)
REQ-032 start, 25 pulses, stop -> km=2, mtr=25, co pulsed twice (after pulses 10 and 20), busy 0 after stop.
REQ-033 start, 10 pulses, 9 pulse-free clocks (macro on) -> wait_sec=2; same with macro off -> wait_sec=0.
REQ-034 start, 160 pulses -> km=15, mtr=159, ovf=1 after pulse 160, co not asserted on pulse 160; new start clears ovf, mtr=0.
REQ-035 start+stop same cycle in IDLE -> busy=1; start+stop same cycle in RUN -> busy=0, values held; pulses in IDLE leave mtr unchanged.
REQ-036 rst asserted mid-trip after 7 pulses, between clock edges -> all outputs 0 before next edge; following pulses ignored until start.
